// File: rtl/gbe_oflow_pkg.sv
// ---------------------------------------------------------------------------
// gbe_oflow_pkg
// Shared definitions for the 10GbE transmit overflow status producer:
//   - FSM state encoding (NORMAL / OFLOW / HOLDOFF, code 3 is illegal)
//   - counter widths for the episode and almost-full counters
//   - bit positions of every field in the 32-bit status word
//   - pack_status(): assembles the status word from its fields
// ---------------------------------------------------------------------------
package gbe_oflow_pkg;

    typedef enum logic [1:0] {
        ST_NORMAL  = 2'd0,
        ST_OFLOW   = 2'd1,
        ST_HOLDOFF = 2'd2
    } oflow_state_e;

    localparam int EPISODE_W = 16;
    localparam int AFULL_W   = 8;

    // Status word field positions
    localparam int BIT_OVF_STICKY   = 31;
    localparam int BIT_AFULL_STICKY = 30;
    localparam int BIT_AFULL_LIVE   = 29;
    localparam int BIT_CTR_SAT      = 28;
    localparam int STATE_HI         = 27;
    localparam int STATE_LO         = 26;
    localparam int RSVD_HI          = 25;
    localparam int RSVD_LO          = 24;
    localparam int AFULL_CNT_HI     = 23;
    localparam int AFULL_CNT_LO     = 16;
    localparam int EPISODE_HI       = 15;
    localparam int EPISODE_LO       = 0;

    // Assemble the status word; the reserved field is always zero.
    function automatic logic [31:0] pack_status(
        input logic                 ovf_sticky,
        input logic                 afull_sticky,
        input logic                 afull_live,
        input logic                 ctr_sat,
        input oflow_state_e         state,
        input logic [AFULL_W-1:0]   afull_cnt,
        input logic [EPISODE_W-1:0] episode_cnt
    );
        logic [31:0] word;
        word                             = 32'h0000_0000;
        word[BIT_OVF_STICKY]             = ovf_sticky;
        word[BIT_AFULL_STICKY]           = afull_sticky;
        word[BIT_AFULL_LIVE]             = afull_live;
        word[BIT_CTR_SAT]                = ctr_sat;
        word[STATE_HI:STATE_LO]          = state;
        word[RSVD_HI:RSVD_LO]            = 2'b00;
        word[AFULL_CNT_HI:AFULL_CNT_LO]  = afull_cnt;
        word[EPISODE_HI:EPISODE_LO]      = episode_cnt;
        return word;
    endfunction

endpackage

// File: rtl/gbe_oflow_status_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter with a synchronous clear. When clr and inc arrive in
// the same cycle the clear is applied first and the increment then counts on
// the cleared value, so the result is 1.
// Ports:
//   clk  in   clock
//   rst  in   synchronous active-high reset
//   clr  in   clear to zero (also clears the saturation flag)
//   inc  in   increment request, ignored once the counter is at all-ones
//   cnt  out  registered count
//   sat  out  registered flag, high once cnt has reached all-ones
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [WIDTH-1:0] cnt,
    output logic             sat
);

    localparam logic [WIDTH-1:0] CNT_ZERO = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] CNT_MAX  = {WIDTH{1'b1}};

    logic [WIDTH-1:0] cnt_r;
    logic             sat_r;
    logic [WIDTH-1:0] cnt_base_s;
    logic [WIDTH-1:0] cnt_nx_s;
    logic             sat_nx_s;

    // Next count: clear first, then a non-saturated increment
    always_comb begin
        cnt_base_s = CNT_ZERO;
        cnt_nx_s   = CNT_ZERO;
        sat_nx_s   = 1'b0;
        if (clr) begin
            cnt_base_s = CNT_ZERO;
        end else begin
            cnt_base_s = cnt_r;
        end
        if (inc && (cnt_base_s != CNT_MAX)) begin
            cnt_nx_s = cnt_base_s + CNT_ONE;
        end else begin
            cnt_nx_s = cnt_base_s;
        end
        sat_nx_s = ((~clr) & sat_r) | (cnt_nx_s == CNT_MAX);
    end

    // Count and saturation flag registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r <= CNT_ZERO;
            sat_r <= 1'b0;
        end else begin
            cnt_r <= cnt_nx_s;
            sat_r <= sat_nx_s;
        end
    end

    assign cnt = cnt_r;
    assign sat = sat_r;

endmodule

// File: rtl/gbe_oflow_status.sv
// ---------------------------------------------------------------------------
// gbe_oflow_status
// Watches the 10GbE core tx_overflow / tx_afull flags, groups overflow cycles
// into episodes separated by an idle holdoff, keeps sticky flags and
// saturating counters, and publishes them as a packed 32-bit status word.
//
// Pipeline: stage 1 registers the inputs, stage 2 holds the FSM / counters /
// stickies, stage 3 registers the status word. An input sampled at edge E is
// visible on status_out after edge E+2; episode_active is one edge earlier.
//
// Ports:
//   user_clk        in   1   sole clock
//   user_rst        in   1   synchronous active-high reset
//   tx_overflow     in   1   core tx overflow (level)
//   tx_afull        in   1   core tx almost-full (level)
//   sw_clr          in   1   software clear (level, acts on rising edge)
//   status_out      out  32  packed status word
//   episode_active  out  1   high while in OFLOW or HOLDOFF
//   first_oflow_ts  out  32  (GBE_OFLOW_TIMESTAMP_EN only) cycle count at the
//                            first episode start after reset / clear
//
// Build option: define GBE_OFLOW_TIMESTAMP_EN to add the free-running cycle
// counter and the first_oflow_ts port.
// ---------------------------------------------------------------------------
module gbe_oflow_status
    import gbe_oflow_pkg::*;
#(
    parameter int HOLDOFF_CYC = 64,
    parameter int HOLDOFF_W   = 8
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        tx_overflow,
    input  logic        tx_afull,
    input  logic        sw_clr,
    output logic [31:0] status_out,
    output logic        episode_active
`ifdef GBE_OFLOW_TIMESTAMP_EN
    ,
    output logic [31:0] first_oflow_ts
`endif
);

    localparam logic                 HOLD_EN   = (HOLDOFF_CYC > 32'sd0);
    localparam logic [HOLDOFF_W-1:0] HOLD_ZERO = {HOLDOFF_W{1'b0}};
    localparam logic [HOLDOFF_W-1:0] HOLD_ONE  = {{(HOLDOFF_W-1){1'b0}}, 1'b1};
    localparam logic [HOLDOFF_W-1:0] HOLD_LOAD =
        HOLDOFF_W'((HOLDOFF_CYC > 32'sd0) ? (HOLDOFF_CYC - 32'sd1) : 32'sd0);

    // Stage 1
    logic ovf_q_r;
    logic afull_q_r;
    logic afull_q_d_r;
    logic sw_clr_q_r;
    logic sw_clr_q_d_r;
    logic sw_clr_armed_r;
    logic clr_pulse_s;
    logic afull_rise_s;

    // Stage 2
    oflow_state_e           state_r;
    oflow_state_e           state_base_s;
    oflow_state_e           state_nx_s;
    logic [HOLDOFF_W-1:0]   hold_cnt_r;
    logic [HOLDOFF_W-1:0]   hold_base_s;
    logic [HOLDOFF_W-1:0]   hold_nx_s;
    logic                   ep_inc_s;
    logic                   ovf_sticky_r;
    logic                   afull_sticky_r;
    logic                   episode_active_r;
    logic [EPISODE_W-1:0]   ep_cnt_s;
    logic                   ep_sat_s;
    logic [AFULL_W-1:0]     afull_cnt_s;
    logic                   afull_sat_s;

    // Stage 3
    logic [31:0]            status_r;

    // A clear only fires after sw_clr has been seen low since reset, so a
    // level already high when reset releases does not count as an edge.
    assign clr_pulse_s  = sw_clr_q_r & ~sw_clr_q_d_r & sw_clr_armed_r;
    assign afull_rise_s = afull_q_r & ~afull_q_d_r;

    // Stage 1: input registers and edge-detect history
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ovf_q_r        <= 1'b0;
            afull_q_r      <= 1'b0;
            afull_q_d_r    <= 1'b0;
            sw_clr_q_r     <= 1'b0;
            sw_clr_q_d_r   <= 1'b0;
            sw_clr_armed_r <= 1'b0;
        end else begin
            ovf_q_r        <= tx_overflow;
            afull_q_r      <= tx_afull;
            afull_q_d_r    <= afull_q_r;
            sw_clr_q_r     <= sw_clr;
            sw_clr_q_d_r   <= sw_clr_q_r;
            sw_clr_armed_r <= sw_clr_armed_r | ~sw_clr;
        end
    end

    // Episode FSM next state; a clear resets the FSM before this cycle's event
    always_comb begin
        state_base_s = ST_NORMAL;
        hold_base_s  = HOLD_ZERO;
        if (clr_pulse_s) begin
            state_base_s = ST_NORMAL;
            hold_base_s  = HOLD_ZERO;
        end else begin
            state_base_s = state_r;
            hold_base_s  = hold_cnt_r;
        end
        state_nx_s = state_base_s;
        hold_nx_s  = hold_base_s;
        ep_inc_s   = 1'b0;
        case (state_base_s)
            ST_NORMAL: begin
                if (ovf_q_r) begin
                    state_nx_s = ST_OFLOW;
                    ep_inc_s   = 1'b1;
                end else begin
                    state_nx_s = ST_NORMAL;
                end
            end
            ST_OFLOW: begin
                if (ovf_q_r) begin
                    state_nx_s = ST_OFLOW;
                end else if (HOLD_EN) begin
                    state_nx_s = ST_HOLDOFF;
                    hold_nx_s  = HOLD_LOAD;
                end else begin
                    state_nx_s = ST_NORMAL;
                end
            end
            ST_HOLDOFF: begin
                if (ovf_q_r) begin
                    // Overflow inside the holdoff window belongs to the same episode
                    state_nx_s = ST_OFLOW;
                end else if (hold_base_s == HOLD_ZERO) begin
                    state_nx_s = ST_NORMAL;
                end else begin
                    hold_nx_s = hold_base_s - HOLD_ONE;
                end
            end
            default: begin
                state_nx_s = ST_NORMAL;
                hold_nx_s  = HOLD_ZERO;
            end
        endcase
    end

    // Stage 2: FSM, holdoff counter, stickies and episode_active
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            state_r          <= ST_NORMAL;
            hold_cnt_r       <= HOLD_ZERO;
            ovf_sticky_r     <= 1'b0;
            afull_sticky_r   <= 1'b0;
            episode_active_r <= 1'b0;
        end else begin
            state_r          <= state_nx_s;
            hold_cnt_r       <= hold_nx_s;
            ovf_sticky_r     <= (~clr_pulse_s & ovf_sticky_r) | ovf_q_r;
            afull_sticky_r   <= (~clr_pulse_s & afull_sticky_r) | afull_q_r;
            episode_active_r <= (state_nx_s != ST_NORMAL);
        end
    end

    sat_counter #(.WIDTH(EPISODE_W)) u_episode_cnt (
        .clk (user_clk),
        .rst (user_rst),
        .clr (clr_pulse_s),
        .inc (ep_inc_s),
        .cnt (ep_cnt_s),
        .sat (ep_sat_s)
    );

    sat_counter #(.WIDTH(AFULL_W)) u_afull_cnt (
        .clk (user_clk),
        .rst (user_rst),
        .clr (clr_pulse_s),
        .inc (afull_rise_s),
        .cnt (afull_cnt_s),
        .sat (afull_sat_s)
    );

    // Stage 3: status word; afull_q_d_r is the stage-2 aligned live afull bit
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            status_r <= 32'h0000_0000;
        end else begin
            status_r <= pack_status(ovf_sticky_r, afull_sticky_r, afull_q_d_r,
                                    ep_sat_s, state_r, afull_cnt_s, ep_cnt_s);
        end
    end

    assign status_out     = status_r;
    assign episode_active = episode_active_r;

`ifdef GBE_OFLOW_TIMESTAMP_EN
    logic [31:0] ts_cnt_r;
    logic [31:0] ts_val_r;
    logic        ts_seen_r;
    logic [31:0] ts_out_r;
    logic [31:0] ts_cnt_nx_s;
    logic [31:0] ts_val_nx_s;
    logic        ts_seen_nx_s;

    // Cycle counter and first-episode latch, clear applied before the latch
    always_comb begin
        ts_cnt_nx_s  = 32'h0000_0000;
        ts_val_nx_s  = 32'h0000_0000;
        ts_seen_nx_s = 1'b0;
        if (clr_pulse_s) begin
            ts_cnt_nx_s  = 32'h0000_0000;
            ts_val_nx_s  = 32'h0000_0000;
            ts_seen_nx_s = 1'b0;
        end else begin
            ts_cnt_nx_s  = ts_cnt_r + 32'h0000_0001;
            ts_val_nx_s  = ts_val_r;
            ts_seen_nx_s = ts_seen_r;
        end
        if (ep_inc_s && !ts_seen_nx_s) begin
            ts_val_nx_s  = clr_pulse_s ? 32'h0000_0000 : ts_cnt_r;
            ts_seen_nx_s = 1'b1;
        end else begin
            ts_seen_nx_s = ts_seen_nx_s;
        end
    end

    // Stage 2 timestamp state and stage 3 output register
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            ts_cnt_r  <= 32'h0000_0000;
            ts_val_r  <= 32'h0000_0000;
            ts_seen_r <= 1'b0;
            ts_out_r  <= 32'h0000_0000;
        end else begin
            ts_cnt_r  <= ts_cnt_nx_s;
            ts_val_r  <= ts_val_nx_s;
            ts_seen_r <= ts_seen_nx_s;
            ts_out_r  <= ts_val_r;
        end
    end

    assign first_oflow_ts = ts_out_r;
`endif

endmodule
